dphy_oserdes_gearbox: RTL and testbench

- Parametrised multi-lane successor to the single-lane D-PHY output SERDES.
- Takes per-lane words of WORD_W bits on a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word OUT_W bits per clock, all lanes in lockstep, into the architecture-specific DDR output primitive.
- Sits between the CSI-2 lane distributor and the DDR primitives. Adds HS enable gating, idle-pattern insertion on underflow, and a sticky underflow flag.

---
 rtl/dphy_pkg.sv | 20 ++
 rtl/dphy_sync_fifo.sv | 70 +++++++
 rtl/dphy_oserdes_gearbox.sv | 197 +++++++++++++++++++
 tb/tb_dphy_oserdes_gearbox.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared state encoding, bit-order constants and helpers for the D-PHY gearbox
package dphy_pkg;

    localparam logic [1:0] DPHY_ST_STOP = 2'd0;
    localparam logic [1:0] DPHY_ST_RUN  = 2'd1;
    localparam logic [1:0] DPHY_ST_IDLE = 2'd2;

    localparam int DPHY_LSB_FIRST = 0;
    localparam int DPHY_MSB_FIRST = 1;

    function automatic int dphy_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dphy_sync_fifo.sv
// rtl/dphy_sync_fifo.sv - single-clock word FIFO with registered ready for the D-PHY gearbox
module dphy_sync_fifo
    import dphy_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [WIDTH-1:0] rdata,
    input  logic             rd_en,
    output logic             empty
);

    localparam int AW = dphy_clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wvalid && wready;
    assign do_rd = rd_en && !empty;
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Ready is registered from the next count so the write side never sees a read-side path.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wready <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count  <= count_nxt;
            wready <= (count_nxt < FULL_COUNT);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dphy_oserdes_gearbox.sv
// rtl/dphy_oserdes_gearbox.sv - multi-lane word-to-beat gearbox feeding the DDR output primitives (option: DPHY_OSERDES_LANE_SKEW_EN)
module dphy_oserdes_gearbox
    import dphy_pkg::*;
#(
    parameter int               LANES     = 2,
    parameter int               WORD_W    = 8,
    parameter int               OUT_W     = 2,
    parameter int               DEPTH     = 4,
    parameter int               MSB_FIRST = 0,
    parameter logic [OUT_W-1:0] IDLE_PAT  = '0
) (
    input  logic                    dphy_clk,
    input  logic                    areset,
    input  logic [LANES*WORD_W-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    hs_en,
    input  logic                    clr_underflow,
`ifdef DPHY_OSERDES_LANE_SKEW_EN
    input  logic [LANES*2-1:0]      lane_skew,
`endif
    output logic [LANES*OUT_W-1:0]  dout,
    output logic                    dout_active,
    output logic                    underflow
);

    localparam int R  = WORD_W / OUT_W;
    localparam int PW = (R > 1) ? dphy_clog2(R) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [PW-1:0]           phase;
    logic [PW-1:0]           phase_nxt;
    logic                    boundary;
    logic                    pop;
    logic                    enter_idle;
    logic                    fifo_empty;
    logic [LANES*WORD_W-1:0] fifo_rdata;
    logic [LANES*WORD_W-1:0] shreg;
    logic [LANES*WORD_W-1:0] shifted;
    logic [LANES*OUT_W-1:0]  beat;
    logic [LANES*OUT_W-1:0]  dout_core;

    dphy_sync_fifo #(
        .WIDTH (LANES * WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (dphy_clk),
        .areset (areset),
        .wdata  (din),
        .wvalid (din_valid),
        .wready (din_ready),
        .rdata  (fifo_rdata),
        .rd_en  (pop),
        .empty  (fifo_empty)
    );

    assign boundary = (phase == LAST_PHASE);

    // Words are never truncated: every exit from RUN or IDLE waits for the phase to wrap.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        pop        = 1'b0;
        enter_idle = 1'b0;
        case (state)
            DPHY_ST_STOP: begin
                if (hs_en && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DPHY_ST_RUN;
                    phase_nxt = '0;
                end
            end
            DPHY_ST_RUN: begin
                if (!boundary) begin
                    phase_nxt = phase + PHASE_ONE;
                end else begin
                    phase_nxt = '0;
                    if (!hs_en) begin
                        state_nxt = DPHY_ST_STOP;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt  = DPHY_ST_IDLE;
                        enter_idle = 1'b1;
                    end
                end
            end
            DPHY_ST_IDLE: begin
                if (!boundary) begin
                    phase_nxt = phase + PHASE_ONE;
                end else begin
                    phase_nxt = '0;
                    if (!hs_en) begin
                        state_nxt = DPHY_ST_STOP;
                    end else if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = DPHY_ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = DPHY_ST_STOP;
                phase_nxt = '0;
            end
        endcase
    end

    always_comb begin
        shifted = '0;
        beat    = '0;
        for (int n = 0; n < LANES; n++) begin
            if (MSB_FIRST == DPHY_MSB_FIRST) begin
                shifted[n*WORD_W +: WORD_W] = shreg[n*WORD_W +: WORD_W] << OUT_W;
                beat[n*OUT_W +: OUT_W]      = shreg[n*WORD_W + WORD_W - OUT_W +: OUT_W];
            end else begin
                shifted[n*WORD_W +: WORD_W] = shreg[n*WORD_W +: WORD_W] >> OUT_W;
                beat[n*OUT_W +: OUT_W]      = shreg[n*WORD_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            state       <= DPHY_ST_STOP;
            phase       <= '0;
            shreg       <= '0;
            dout_core   <= '0;
            dout_active <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (pop) begin
                shreg <= fifo_rdata;
            end else if (state == DPHY_ST_RUN) begin
                shreg <= shifted;
            end
            case (state)
                DPHY_ST_RUN: begin
                    dout_core   <= beat;
                    dout_active <= 1'b1;
                end
                DPHY_ST_IDLE: begin
                    dout_core   <= {LANES{IDLE_PAT}};
                    dout_active <= 1'b0;
                end
                default: begin
                    dout_core   <= '0;
                    dout_active <= 1'b0;
                end
            endcase
            if (enter_idle) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef DPHY_OSERDES_LANE_SKEW_EN
    logic [OUT_W-1:0] skew_dly [LANES][3];

    always_ff @(posedge dphy_clk or posedge areset) begin
        if (areset) begin
            for (int n = 0; n < LANES; n++) begin
                for (int t = 0; t < 3; t++) begin
                    skew_dly[n][t] <= IDLE_PAT;
                end
            end
        end else begin
            for (int n = 0; n < LANES; n++) begin
                skew_dly[n][0] <= dout_core[n*OUT_W +: OUT_W];
                skew_dly[n][1] <= skew_dly[n][0];
                skew_dly[n][2] <= skew_dly[n][1];
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int n = 0; n < LANES; n++) begin
            case (lane_skew[n*2 +: 2])
                2'd0:    dout[n*OUT_W +: OUT_W] = dout_core[n*OUT_W +: OUT_W];
                2'd1:    dout[n*OUT_W +: OUT_W] = skew_dly[n][0];
                2'd2:    dout[n*OUT_W +: OUT_W] = skew_dly[n][1];
                default: dout[n*OUT_W +: OUT_W] = skew_dly[n][2];
            endcase
        end
    end
`else
    assign dout = dout_core;
`endif

endmodule

// File: tb/tb_dphy_oserdes_gearbox.sv
// tb/tb_dphy_oserdes_gearbox.sv - directed self-checking bench for the D-PHY output gearbox
module tb_dphy_oserdes_gearbox;

    logic        dphy_clk = 1'b0;
    logic        areset;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        hs_en;
    logic        clr_underflow;
    logic [3:0]  dout;
    logic        dout_active;
    logic        underflow;

    logic [7:0]  m_din;
    logic        m_din_valid;
    logic        m_din_ready;
    logic        m_hs_en;
    logic        m_clr;
    logic [3:0]  m_dout;
    logic        m_dout_active;
    logic        m_underflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] sw [8] = '{16'h3CA5, 16'hF00F, 16'h6996, 16'h1248,
                            16'hFEDC, 16'h0BAD, 16'hC0DE, 16'h7E81};

    always #5 dphy_clk = ~dphy_clk;

    dphy_oserdes_gearbox #(
        .LANES (2), .WORD_W (8), .OUT_W (2), .DEPTH (4), .MSB_FIRST (0), .IDLE_PAT (2'b10)
    ) u_dut (
        .dphy_clk      (dphy_clk),
        .areset        (areset),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .hs_en         (hs_en),
        .clr_underflow (clr_underflow),
        .dout          (dout),
        .dout_active   (dout_active),
        .underflow     (underflow)
    );

    dphy_oserdes_gearbox #(
        .LANES (1), .WORD_W (8), .OUT_W (4), .DEPTH (4), .MSB_FIRST (1), .IDLE_PAT (4'h0)
    ) u_msb (
        .dphy_clk      (dphy_clk),
        .areset        (areset),
        .din           (m_din),
        .din_valid     (m_din_valid),
        .din_ready     (m_din_ready),
        .hs_en         (m_hs_en),
        .clr_underflow (m_clr),
        .dout          (m_dout),
        .dout_active   (m_dout_active),
        .underflow     (m_underflow)
    );

    task automatic tick();
        @(posedge dphy_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input int b);
        logic [15:0] w;
        int p;
        w = sw[b / 4];
        p = b % 4;
        return 32'({w[8 + 2*p +: 2], w[2*p +: 2]});
    endfunction

    initial begin
        int idx;
        int beats;
        int gaps;
        int waited;
        logic rdy;
        logic saw_low;
        logic recovered;

        areset = 1'b1; din = '0; din_valid = 1'b0; hs_en = 1'b0; clr_underflow = 1'b0;
        m_din = '0; m_din_valid = 1'b0; m_hs_en = 1'b0; m_clr = 1'b0;

        repeat (3) tick();
        check("rst_dout",      32'(dout),        32'h0);
        check("rst_active",    32'(dout_active), 32'h0);
        check("rst_underflow", 32'(underflow),   32'h0);
        check("rst_ready",     32'(din_ready),   32'h0);
        areset = 1'b0;
        tick();
        check("ready_after_rst",   32'(din_ready),   32'h1);
        check("m_ready_after_rst", 32'(m_din_ready), 32'h1);

        // MSB-first instance: 8'h5E leaves as 5 then E
        m_hs_en = 1'b1; m_din = 8'h5E; m_din_valid = 1'b1;
        tick();
        m_din_valid = 1'b0;
        tick();
        check("msb_lat_n1", 32'(m_dout_active), 32'h0);
        tick();
        check("msb_beat0",  32'(m_dout),        32'h5);
        check("msb_act0",   32'(m_dout_active), 32'h1);
        tick();
        check("msb_beat1",  32'(m_dout),        32'hE);
        tick();
        check("msb_idle_act", 32'(m_dout_active), 32'h0);
        check("msb_underflow", 32'(m_underflow),  32'h1);

        // Single word A5_3C, latency two edges after the write
        hs_en = 1'b1; din = 16'hA53C; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        check("t1_lat_n1",  32'(dout_active), 32'h0);
        tick();
        check("t1_beat0",   32'(dout),        32'h4);
        check("t1_act0",    32'(dout_active), 32'h1);
        tick();
        check("t1_beat1",   32'(dout),        32'h7);
        tick();
        check("t1_beat2",   32'(dout),        32'hB);
        check("t1_uf_pre",  32'(underflow),   32'h0);
        tick();
        check("t1_beat3",   32'(dout),        32'h8);
        check("t1_act3",    32'(dout_active), 32'h1);
        check("t1_uf_set",  32'(underflow),   32'h1);
        tick();
        check("t1_idle",    32'(dout),        32'hA);
        check("t1_idle_act", 32'(dout_active), 32'h0);

        // Underflow recovery: second word waits for the idle word boundary
        din = 16'h1234; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("t3_idle_a",  32'(dout), 32'hA);
        tick();
        check("t3_idle_b",  32'(dout), 32'hA);
        tick();
        check("t3_idle_c",  32'(dout), 32'hA);
        check("t3_idle_act", 32'(dout_active), 32'h0);
        tick();
        check("t3_beat0",   32'(dout),        32'h8);
        check("t3_act0",    32'(dout_active), 32'h1);
        tick();
        check("t3_beat1",   32'(dout), 32'h1);
        tick();
        check("t3_beat2",   32'(dout), 32'h7);
        tick();
        check("t3_beat3",   32'(dout), 32'h0);
        check("t3_act3",    32'(dout_active), 32'h1);
        tick();
        check("t3_idle_again", 32'(dout), 32'hA);
        clr_underflow = 1'b1;
        tick();
        clr_underflow = 1'b0;
        check("t3_uf_clear", 32'(underflow), 32'h0);

        // hs_en dropped at phase 1: word completes, next word held in the FIFO
        din = 16'h1BE4; din_valid = 1'b1;
        tick();
        din = 16'h5AC3;
        tick();
        din_valid = 1'b0;
        check("t4_idle",    32'(dout), 32'hA);
        tick();
        check("t4_beat0",   32'(dout), 32'hC);
        hs_en = 1'b0;
        tick();
        check("t4_beat1",   32'(dout), 32'h9);
        tick();
        check("t4_beat2",   32'(dout), 32'h6);
        tick();
        check("t4_beat3",   32'(dout), 32'h3);
        check("t4_act3",    32'(dout_active), 32'h1);
        tick();
        check("t4_stop_dout", 32'(dout),        32'h0);
        check("t4_stop_act",  32'(dout_active), 32'h0);
        check("t4_ready",     32'(din_ready),   32'h1);
        tick();
        check("t4_stop_hold", 32'(dout_active), 32'h0);
        hs_en = 1'b1;
        tick();
        check("t4_resume_lat", 32'(dout_active), 32'h0);
        tick();
        check("t4_y_beat0", 32'(dout), 32'hB);
        tick();
        check("t4_y_beat1", 32'(dout), 32'h8);
        tick();
        check("t4_y_beat2", 32'(dout), 32'h4);
        tick();
        check("t4_y_beat3", 32'(dout), 32'h7);
        tick();
        check("t4_idle",    32'(dout),      32'hA);
        check("t4_uf",      32'(underflow), 32'h1);

        // Streaming: prefill to full with hs_en low, then stream 8 words
        hs_en = 1'b0;
        repeat (5) tick();
        check("t2_stopped", 32'(dout_active), 32'h0);
        for (int k = 0; k < 4; k++) begin
            din = sw[k]; din_valid = 1'b1;
            tick();
            check("t2_prefill_ready", 32'(din_ready), (k < 3) ? 32'h1 : 32'h0);
        end
        hs_en = 1'b1; clr_underflow = 1'b1;
        idx = 4; din = sw[4];
        beats = 0; gaps = 0; saw_low = 1'b1; recovered = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rdy = din_ready;
            tick();
            if (din_valid && rdy) idx++;
            if (idx >= 8) din_valid = 1'b0;
            else din = sw[idx];
            if (saw_low && din_ready) recovered = 1'b1;
            if (dout_active) begin
                if (beats < 32) check("t2_beat", 32'(dout), exp_beat(beats));
                beats++;
                if (beats == 32) begin
                    check("t2_uf_set_wins", 32'(underflow), 32'h1);
                    clr_underflow = 1'b0;
                end
            end else if (beats > 0 && beats < 32) begin
                gaps++;
            end
        end
        check("t2_beats",     32'(beats),     32'd32);
        check("t2_gaps",      32'(gaps),      32'd0);
        check("t2_accepted",  32'(idx),       32'd8);
        check("t2_recovered", 32'(recovered), 32'h1);

        // Async reset mid-word flushes the FIFO
        check("t6_uf_pre", 32'(underflow), 32'h1);
        din = 16'hA53C; din_valid = 1'b1;
        tick();
        din = 16'h1234;
        tick();
        din_valid = 1'b0;
        waited = 0;
        while (!dout_active && waited < 12) begin
            tick();
            waited++;
        end
        check("t6_pre_active", 32'(dout_active), 32'h1);
        tick();
        #2;
        areset = 1'b1;
        #1;
        check("t6_rst_dout",   32'(dout),        32'h0);
        check("t6_rst_active", 32'(dout_active), 32'h0);
        check("t6_rst_uf",     32'(underflow),   32'h0);
        check("t6_rst_ready",  32'(din_ready),   32'h0);
        tick();
        areset = 1'b0;
        tick();
        check("t6_ready", 32'(din_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_flushed", 32'(dout_active), 32'h0);
        end
        din = 16'hA53C; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        check("t6_lat_n1",  32'(dout_active), 32'h0);
        tick();
        check("t6_beat0",   32'(dout),        32'h4);
        check("t6_act0",    32'(dout_active), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
